// File: rtl/wb_arbiter_2m.sv
// ============================================================================
// wb_arbiter_2m : two-master / one-slave Wishbone arbiter, round-robin
// re-arbitration at every completed transfer. Optional bus timeout: WB_ARB_TIMEOUT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_arbiter_2m #(
  parameter bit          M1_PRIO   = 1'b0,
  parameter int unsigned TO_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        res_ni,
  input  logic [14:0] m0_adr_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_vda_i,
  input  logic        m0_vpa_i,
  input  logic [15:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [15:0] m0_dat_o,
  input  logic [14:0] m1_adr_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [1:0]  m1_sel_i,
  input  logic [15:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [15:0] m1_dat_o,
  output logic [14:0] s_adr_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [1:0]  s_sel_o,
  output logic        s_vda_o,
  output logic        s_vpa_o,
  output logic [15:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [15:0] s_dat_i,
  output logic [1:0]  gnt_o,
  output logic        to_err_o,
  input  logic        to_clr_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_last;
  logic       w_last_nxt;
  logic       w_req0;
  logic       w_req1;
  logic       w_own0;
  logic       w_own1;
  logic       w_to;
  logic       w_done;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;
  assign w_own0 = (r_state == S_OWN0);
  assign w_own1 = (r_state == S_OWN1);
  assign w_done = (w_own0 | w_own1) & (s_ack_i | w_to);

  // "last" names the master served most recently; a tie goes to the other one.
  function automatic logic [1:0] arb(input logic last, input logic r0, input logic r1);
    logic [1:0] res;
    res = S_IDLE;
    if (r0 && r1)
      res = (M1_PRIO || !last) ? S_OWN1 : S_OWN0;
    else if (r0)
      res = S_OWN0;
    else if (r1)
      res = S_OWN1;
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_last_nxt = r_last;
    case (r_state)
      S_IDLE: w_next = arb(r_last, w_req0, w_req1);
      S_OWN0: begin
        if (w_done) begin
          w_last_nxt = 1'b0;
          w_next     = arb(1'b0, w_req0, w_req1);
        end else if (!m0_cyc_i) begin
          w_next = arb(r_last, w_req0, w_req1);
        end
      end
      S_OWN1: begin
        if (w_done) begin
          w_last_nxt = 1'b1;
          w_next     = arb(1'b1, w_req0, w_req1);
        end else if (!m1_cyc_i) begin
          w_next = arb(r_last, w_req0, w_req1);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_adr_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_sel_o = '0;
    s_vda_o = 1'b0;
    s_vpa_o = 1'b0;
    s_dat_o = '0;
    case (r_state)
      S_OWN0: begin
        s_adr_o = m0_adr_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_sel_o = m0_sel_i;
        s_vda_o = m0_vda_i;
        s_vpa_o = m0_vpa_i;
        s_dat_o = m0_dat_i;
      end
      S_OWN1: begin
        s_adr_o = m1_adr_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_sel_o = m1_sel_i;
        s_vda_o = 1'b1;
        s_vpa_o = 1'b0;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_ack_o = w_own0 & (s_ack_i | w_to);
  assign m1_ack_o = w_own1 & (s_ack_i | w_to);
  assign m0_dat_o = w_to ? 16'h0000 : s_dat_i;
  assign m1_dat_o = w_to ? 16'h0000 : s_dat_i;
  assign gnt_o    = {w_own1, w_own0};

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_to_err;
  logic       w_stall;

  assign w_stall  = (w_own0 | w_own1) & s_stb_o & ~s_ack_i;
  assign w_to     = w_stall & (r_to_cnt == 8'(TO_CYCLES - 1));
  assign to_err_o = r_to_err;

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (w_done || (w_next != r_state))
        r_to_cnt <= '0;
      else if (w_stall)
        r_to_cnt <= r_to_cnt + 8'd1;
      // a fresh timeout wins over a simultaneous clear
      if (w_to)
        r_to_err <= 1'b1;
      else if (to_clr_i)
        r_to_err <= 1'b0;
    end
  end
`else
  logic w_unused;
  assign w_to     = 1'b0;
  assign to_err_o = 1'b0;
  assign w_unused = to_clr_i | (TO_CYCLES == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: round-robin (k=0) and M1_PRIO (k=1) instances on shared
// stimulus, compared every cycle against a transfer-level model plus directed literals.
`default_nettype none

module tb_wb_arbiter_2m;
  localparam int TO = 15;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        res_ni = 1'b0;
  logic [14:0] m0_adr, m1_adr;
  logic        m0_we, m0_cyc, m0_stb, m0_vda, m0_vpa, m1_we, m1_cyc, m1_stb;
  logic [1:0]  m0_sel, m1_sel;
  logic [15:0] m0_dat, m1_dat, s_dat_i;
  logic        s_ack_i, to_clr;

  logic        m0_ack [2];
  logic        m1_ack [2];
  logic [15:0] m0_do [2];
  logic [15:0] m1_do [2];
  logic [14:0] s_adr [2];
  logic        s_we [2];
  logic        s_cyc [2];
  logic        s_stb [2];
  logic [1:0]  s_sel [2];
  logic        s_vda [2];
  logic        s_vpa [2];
  logic [15:0] s_dat [2];
  logic [1:0]  gnt [2];
  logic        to_err [2];

  int total = 0;
  int bad = 0;
  int n_ack0 [2] = '{0, 0};
  int n_ack1 [2] = '{0, 0};

  // model: owner 0 = idle, 1 = m0, 2 = m1
  int mo [2];
  bit ml [2];
  int mc [2];
  bit me [2];

  always #5 clk_i = ~clk_i;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    wb_arbiter_2m #(.M1_PRIO(k == 1), .TO_CYCLES(TO)) u_dut (
      .clk_i(clk_i), .res_ni(res_ni),
      .m0_adr_i(m0_adr), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
      .m0_sel_i(m0_sel), .m0_vda_i(m0_vda), .m0_vpa_i(m0_vpa), .m0_dat_i(m0_dat),
      .m0_ack_o(m0_ack[k]), .m0_dat_o(m0_do[k]),
      .m1_adr_i(m1_adr), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
      .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack[k]), .m1_dat_o(m1_do[k]),
      .s_adr_o(s_adr[k]), .s_we_o(s_we[k]), .s_cyc_o(s_cyc[k]), .s_stb_o(s_stb[k]),
      .s_sel_o(s_sel[k]), .s_vda_o(s_vda[k]), .s_vpa_o(s_vpa[k]), .s_dat_o(s_dat[k]),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(gnt[k]), .to_err_o(to_err[k]),
      .to_clr_i(to_clr)
    );
  end

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int arb(bit prio, bit last, bit r0, bit r1);
    if (r0 && r1) return (prio || !last) ? 2 : 1;
    if (r0) return 1;
    if (r1) return 2;
    return 0;
  endfunction

  function automatic bit own_stb(int k);
    return (mo[k] == 1) ? m0_stb : (mo[k] == 2) ? m1_stb : 1'b0;
  endfunction

  function automatic bit stalled(int k);
    return mo[k] != 0 && own_stb(k) && !s_ack_i;
  endfunction

  function automatic bit exp_to(int k);
    return TO_EN && stalled(k) && mc[k] == TO - 1;
  endfunction

  function automatic bit done(int k);
    return mo[k] != 0 && (s_ack_i || exp_to(k));
  endfunction

  function automatic int nxt_owner(int k);
    bit r0 = m0_cyc && m0_stb;
    bit r1 = m1_cyc && m1_stb;
    bit oc = (mo[k] == 1) ? m0_cyc : (mo[k] == 2) ? m1_cyc : 1'b0;
    if (mo[k] == 0) return arb(k == 1, ml[k], r0, r1);
    if (done(k)) return arb(k == 1, mo[k] == 2, r0, r1);
    if (!oc) return arb(k == 1, ml[k], r0, r1);
    return mo[k];
  endfunction

  always @(posedge clk_i or negedge res_ni) begin
    for (int k = 0; k < 2; k++) begin
      if (!res_ni) begin
        mo[k] <= 0;
        ml[k] <= 1'b1;
        mc[k] <= 0;
        me[k] <= 1'b0;
      end else begin
        mo[k] <= nxt_owner(k);
        ml[k] <= done(k) ? (mo[k] == 2) : ml[k];
        mc[k] <= (done(k) || nxt_owner(k) != mo[k]) ? 0 : stalled(k) ? mc[k] + 1 : mc[k];
        me[k] <= exp_to(k) ? 1'b1 : to_clr ? 1'b0 : me[k];
      end
    end
  end

  task automatic compare(input int k);
    logic [37:0] bus;
    logic        a0, a1;
    logic [15:0] rd;
    bus = '0;
    if (mo[k] == 1) bus = {m0_adr, m0_we, m0_cyc, m0_stb, m0_sel, m0_vda, m0_vpa, m0_dat};
    if (mo[k] == 2) bus = {m1_adr, m1_we, m1_cyc, m1_stb, m1_sel, 1'b1, 1'b0, m1_dat};
    a0 = (mo[k] == 1) && (s_ack_i || exp_to(k));
    a1 = (mo[k] == 2) && (s_ack_i || exp_to(k));
    rd = exp_to(k) ? 16'h0000 : s_dat_i;
    chk("slave_bus", k, {s_adr[k], s_we[k], s_cyc[k], s_stb[k], s_sel[k], s_vda[k], s_vpa[k], s_dat[k]}, bus);
    chk("acks", k, {m0_ack[k], m1_ack[k]}, {a0, a1});
    chk("rdata", k, {m0_do[k], m1_do[k]}, {rd, rd});
    chk("gnt", k, gnt[k], (mo[k] == 1) ? 2'b01 : (mo[k] == 2) ? 2'b10 : 2'b00);
    chk("to_err", k, to_err[k], me[k]);
    if (m0_ack[k]) n_ack0[k]++;
    if (m1_ack[k]) n_ack1[k]++;
  endtask

  always @(negedge clk_i) begin
    compare(0);
    compare(1);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_masters;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
  endtask

  task automatic do_reset;
    idle_masters();
    s_ack_i = 0; to_clr = 0;
    res_ni = 0;
    tick(); tick();
    res_ni = 1;
    tick();
  endtask

  task automatic set_m0(input logic [14:0] a, input bit vpa);
    m0_adr = a; m0_we = 0; m0_sel = 2'b11; m0_vda = !vpa; m0_vpa = vpa;
    m0_cyc = 1; m0_stb = 1;
  endtask

  task automatic set_m1(input logic [14:0] a, input bit we, input logic [15:0] d);
    m1_adr = a; m1_we = we; m1_sel = 2'b11; m1_dat = d; m1_cyc = 1; m1_stb = 1;
  endtask

  initial begin
    int a0, a1;
    m0_adr = 0; m0_we = 0; m0_sel = 0; m0_vda = 0; m0_vpa = 0; m0_dat = 16'h0F0F;
    m1_adr = 0; m1_we = 0; m1_sel = 0; m1_dat = 0;
    idle_masters();
    s_ack_i = 0; s_dat_i = 0; to_clr = 0;
    tick(); tick();
    chk("rst_gnt", 0, gnt[0], 2'b00);
    chk("rst_cyc", 0, s_cyc[0], 1'b0);
    chk("rst_err", 0, to_err[0], 1'b0);

    // single m0 read, two wait states
    res_ni = 1;
    tick();
    a0 = n_ack0[0];
    set_m0(15'h0010, 1'b0);
    #1 chk("t1_lat0", 0, s_cyc[0], 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("t1_cyc", k, s_cyc[k], 1'b1);
      chk("t1_gnt", k, gnt[k], 2'b01);
      chk("t1_adr", k, s_adr[k], 15'h0010);
    end
    tick(); tick();
    s_ack_i = 1; s_dat_i = 16'h1234;
    #1 chk("t1_ack", 0, m0_ack[0], 1'b1);
    chk("t1_dat", 0, m0_do[0], 16'h1234);
    tick();
    idle_masters(); s_ack_i = 0;
    tick(); tick();
    chk("t1_npulse", 0, n_ack0[0] - a0, 1);

    // simultaneous request from IDLE after reset
    do_reset();
    set_m0(15'h0020, 1'b0);
    set_m1(15'h4000, 1'b1, 16'hBEEF);
    s_dat_i = 16'h5555;
    tick();
    chk("t2_gnt0", 0, gnt[0], 2'b01);
    chk("t2_gnt_prio", 1, gnt[1], 2'b10);
    s_ack_i = 1;
    #1 chk("t2_ack0", 0, {m0_ack[0], m1_ack[0]}, 2'b10);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack_i = 0;
    #1 chk("t2_gnt1", 0, gnt[0], 2'b10);
    chk("t2_wr", 0, {s_adr[0], s_we[0], s_dat[0]}, {15'h4000, 1'b1, 16'hBEEF});
    chk("t2_qual", 0, {s_vda[0], s_vpa[0]}, 2'b10);
    s_ack_i = 1;
    #1 chk("t2_ack1", 0, m1_ack[0], 1'b1);
    tick();
    idle_masters(); s_ack_i = 0;
    tick(); tick();

    // both request continuously: alternation (k=0) vs m1 priority (k=1)
    do_reset();
    set_m0(15'h0100, 1'b1);
    set_m1(15'h0200, 1'b0, 16'h0);
    a1 = n_ack0[1];
    tick();
    for (int t = 0; t < 8; t++) begin
      s_ack_i = 0;
      tick();
      s_ack_i = 1; s_dat_i = 16'(t);
      #1 chk("t3_alt", 0, gnt[0], (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("t4_prio", 1, gnt[1], 2'b10);
      tick();
    end
    s_ack_i = 0;
    idle_masters();
    chk("t4_m0_never", 1, n_ack0[1] - a1, 0);
    tick(); tick();

    // asynchronous reset while m1 owns mid-cycle
    do_reset();
    set_m1(15'h0300, 1'b0, 16'h0);
    tick(); tick();
    #2 res_ni = 0; s_ack_i = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t5_cyc", k, s_cyc[k], 1'b0);
      chk("t5_ack", k, m1_ack[k], 1'b0);
      chk("t5_gnt", k, gnt[k], 2'b00);
    end
    s_ack_i = 0;
    set_m0(15'h0301, 1'b0);
    tick();
    res_ni = 1;
    tick();
    chk("t5_last", 0, gnt[0], 2'b01);
    idle_masters();
    tick(); tick();

    // hung slave: timeout ack on the 15th stalled clock when enabled
    do_reset();
    s_dat_i = 16'hDEAD;
    set_m0(15'h0400, 1'b0);
    tick();
    for (int i = 1; i < TO; i++) begin
      chk("t6_noack", 0, m0_ack[0], 1'b0);
      tick();
    end
    chk("t6_ack", 0, m0_ack[0], TO_EN);
    chk("t6_dat", 0, m0_do[0], TO_EN ? 16'h0000 : 16'hDEAD);
    chk("t6_err0", 0, to_err[0], 1'b0);
    tick();
    chk("t6_err", 0, to_err[0], TO_EN);
    idle_masters();
    tick(); tick();
    chk("t6_sticky", 0, to_err[0], TO_EN);
    to_clr = 1;
    tick();
    to_clr = 0;
    chk("t6_clr", 0, to_err[0], 1'b0);
    to_clr = 1;
    set_m0(15'h0401, 1'b0);
    tick();
    for (int i = 1; i < TO; i++) tick();
    tick();
    to_clr = 0;
    chk("t6_set_wins", 0, to_err[0], TO_EN);
    idle_masters();
    tick();
    to_clr = 1;
    tick();
    to_clr = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
